// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command front end and the
// downstream command processor.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2,
    HOLD    = 2'd3
  } ctrl_state_t;

  localparam int unsigned FRAME_BYTES = 3;

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_WR_REG   = 8'h05;
  localparam logic [7:0] OP_RD_REG   = 8'hA0;
  localparam logic [7:0] OP_RD_BURST = 8'hA1;
  localparam logic [7:0] OP_STATUS   = 8'h77;

endpackage

// File: rtl/uart_cmd_ctrl.sv
// Assembles 3-byte command frames from the UART receiver, drops partial
// frames on inter-byte timeout and presents frames under valid/ack.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_byte,
  output logic        clr_rdy,
  output logic        cmd_vld,
  output logic [7:0]  cmd_op,
  output logic [15:0] cmd_data,
  input  logic        cmd_ack,
  output logic        frame_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  ctrl_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clr_rdy_q, clr_rdy_d;
  logic          cmd_vld_q, cmd_vld_d;
  logic [7:0]    cmd_op_q, cmd_op_d;
  logic [15:0]   cmd_data_q, cmd_data_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    op_q, op_d;
  logic [7:0]    hi_q, hi_d;
  logic          capture_s;
  logic          timeout_s;

  // The !clr_rdy term masks the stale flag still high in the clear cycle.
  assign capture_s = rx_rdy && !clr_rdy_q;
  assign timeout_s = (cnt_q == CNT_MAX);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_rdy_d   = 1'b0;
    cmd_vld_d   = cmd_vld_q;
    cmd_op_d    = cmd_op_q;
    cmd_data_d  = cmd_data_q;
    frame_err_d = 1'b0;
    op_d        = op_q;
    hi_d        = hi_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (capture_s) begin
          op_d      = rx_byte;
          clr_rdy_d = 1'b1;
          state_d   = WAIT_HI;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_HI: begin
        if (capture_s) begin
          hi_d      = rx_byte;
          clr_rdy_d = 1'b1;
          cnt_d     = '0;
          state_d   = WAIT_LO;
        end else if (timeout_s) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LO: begin
        // Outputs are committed only here, so a dropped frame never leaks.
        if (capture_s) begin
          cmd_op_d   = op_q;
          cmd_data_d = {hi_q, rx_byte};
          cmd_vld_d  = 1'b1;
          clr_rdy_d  = 1'b1;
          cnt_d      = '0;
          state_d    = HOLD;
        end else if (timeout_s) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        cnt_d = '0;
        if (cmd_ack) begin
          cmd_vld_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        cnt_d     = '0;
        cmd_vld_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      clr_rdy_q   <= 1'b0;
      cmd_vld_q   <= 1'b0;
      cmd_op_q    <= 8'h00;
      cmd_data_q  <= 16'h0000;
      frame_err_q <= 1'b0;
      op_q        <= 8'h00;
      hi_q        <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_rdy_q   <= clr_rdy_d;
      cmd_vld_q   <= cmd_vld_d;
      cmd_op_q    <= cmd_op_d;
      cmd_data_q  <= cmd_data_d;
      frame_err_q <= frame_err_d;
      op_q        <= op_d;
      hi_q        <= hi_d;
    end
  end

  assign clr_rdy   = clr_rdy_q;
  assign cmd_vld   = cmd_vld_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_data  = cmd_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: directed frames through a small
// receiver model, expected frames queued at issue and checked by a monitor.
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        clr_rdy;
  logic        cmd_vld;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        cmd_ack = 1'b0;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int clr_pulses = 0;
  int fe_pulses = 0;
  int last_clr_cyc = 0;
  int last_fe_cyc = 0;
  logic hold_ack = 1'b0;
  logic [23:0] exp_q[$];
  logic [23:0] held = 24'h0;
  logic [23:0] exp_f;
  logic vld_p = 1'b0;
  logic clr_p = 1'b0;
  logic fe_p = 1'b0;

  uart_cmd_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_byte(rx_byte),
    .clr_rdy(clr_rdy), .cmd_vld(cmd_vld), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ack(cmd_ack), .frame_err(frame_err)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each new frame and checks pulse shapes.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      vld_p = 1'b0;
      clr_p = 1'b0;
      fe_p  = 1'b0;
    end else begin
      if (cmd_vld && !vld_p) begin
        if (exp_q.size() == 0) begin
          chk("frame_queued", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_f = exp_q.pop_front();
          chk("cmd_op", 32'(cmd_op), 32'(exp_f[23:16]));
          chk("cmd_data", 32'(cmd_data), 32'(exp_f[15:0]));
        end
        held = {cmd_op, cmd_data};
      end else if (cmd_vld && vld_p) begin
        chk("hold_stable", 32'({cmd_op, cmd_data}), 32'(held));
      end
      if (!cmd_vld && vld_p) chk("no_capture_on_ack_edge", 32'(clr_rdy), 32'd0);
      if (clr_rdy) begin
        if (clr_p) chk("clr_rdy_one_cycle", 32'(clr_p), 32'd0);
        else begin
          clr_pulses++;
          last_clr_cyc = cyc;
        end
      end
      if (frame_err) begin
        chk("frame_err_no_vld", 32'(cmd_vld), 32'd0);
        if (fe_p) chk("frame_err_one_cycle", 32'(fe_p), 32'd0);
        else begin
          fe_pulses++;
          last_fe_cyc = cyc;
        end
      end
      vld_p = cmd_vld;
      clr_p = clr_rdy;
      fe_p  = frame_err;
    end
  end

  // Downstream: ack one cycle after cmd_vld unless held off.
  initial forever begin
    @(negedge clk);
    cmd_ack = cmd_vld && !cmd_ack && !hold_ack;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit seen = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    rx_byte = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (clr_rdy) seen = 1'b1;
    end
    chk("byte_consumed", 32'(seen), 32'd1);
    @(posedge clk);
    #1 rx_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] hi,
                            input logic [7:0] lo, input int gap);
    logic [7:0] bytes [FRAME_BYTES];
    bytes[0] = op;
    bytes[1] = hi;
    bytes[2] = lo;
    exp_q.push_back({op, hi, lo});
    for (int i = 0; i < FRAME_BYTES; i++) send_byte(bytes[i], gap);
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !cmd_vld) done = 1'b1;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_clr_rdy"}, 32'(clr_rdy), 32'd0);
    chk({tag, "_cmd_vld"}, 32'(cmd_vld), 32'd0);
    chk({tag, "_cmd_op"}, 32'(cmd_op), 32'h00);
    chk({tag, "_cmd_data"}, 32'(cmd_data), 32'h0000);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    int c0;
    int f0;
    int c2;
    bit got;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic frame: three single-cycle clears.
    c0 = clr_pulses;
    send_frame(OP_WR_REG, 8'h12, 8'h34, 1);
    wait_done("t1_done");
    chk("t1_clr_pulses", 32'(clr_pulses - c0), 32'd3);

    // Back-to-back bytes, flag still high during the clear cycle.
    c0 = clr_pulses;
    send_frame(8'h3C, 8'h5A, 8'hC3, 0);
    wait_done("t2_done");
    chk("t2_clr_pulses", 32'(clr_pulses - c0), 32'd3);

    // Partial frame times out.
    f0 = fe_pulses;
    send_byte(OP_RD_REG, 1);
    send_byte(8'h01, 1);
    c2 = last_clr_cyc;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (fe_pulses != f0) got = 1'b1;
    end
    chk("t3_frame_err_seen", 32'(got), 32'd1);
    chk("t3_frame_err_delay", 32'(last_fe_cyc - c2), 32'(TO));
    repeat (20) @(negedge clk);
    chk("t3_frame_err_count", 32'(fe_pulses - f0), 32'd1);
    chk("t3_cmd_vld_low", 32'(cmd_vld), 32'd0);
    chk("t3_cmd_op_kept", 32'(cmd_op), 32'h3C);
    send_frame(OP_RD_BURST, 8'hBE, 8'hEF, 1);
    wait_done("t3_done");

    // Ack held off with the next opcode pending.
    hold_ack = 1'b1;
    send_frame(8'h10, 8'h20, 8'h30, 1);
    exp_q.push_back({OP_STATUS, 8'h88, 8'h99});
    @(posedge clk);
    #1;
    rx_byte = OP_STATUS;
    rx_rdy  = 1'b1;
    c0 = clr_pulses;
    repeat (50) @(negedge clk);
    chk("t4_vld_held", 32'(cmd_vld), 32'd1);
    chk("t4_no_clr", 32'(clr_pulses - c0), 32'd0);
    chk("t4_op_held", 32'(cmd_op), 32'h10);
    chk("t4_data_held", 32'(cmd_data), 32'h2030);
    hold_ack = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (!cmd_vld) got = 1'b1;
    end
    chk("t4_vld_dropped", 32'(got), 32'd1);
    @(negedge clk);
    chk("t4_capture_after_ack", 32'(clr_rdy), 32'd1);
    @(posedge clk);
    #1 rx_rdy = 1'b0;
    send_byte(8'h88, 1);
    send_byte(8'h99, 1);
    wait_done("t4_done");

    // Bytes land exactly on the timeout cycle: capture wins.
    f0 = fe_pulses;
    exp_q.push_back({8'hB0, 8'hB1, 8'hB2});
    send_byte(8'hB0, 1);
    send_byte(8'hB1, TO - 2);
    send_byte(8'hB2, TO - 2);
    wait_done("t5_done");
    chk("t5_no_frame_err", 32'(fe_pulses - f0), 32'd0);

    // Reset mid-frame.
    f0 = fe_pulses;
    send_byte(8'hC0, 1);
    send_byte(8'hC1, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    send_frame(8'hD0, 8'hD1, 8'hD2, 1);
    wait_done("t6_done");
    chk("t6_no_frame_err", 32'(fe_pulses - f0), 32'd0);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
